guess_game_n: RTL and testbench
===============================

Name: guess_game_n

Overview:
Parametrised successor to the single-target guessing game. It shows a pseudo-random one-hot target on LED and scores player switch presses on G. It adds N-wide generalisation, a free-running LFSR target source, a per-round timeout, a lives counter, a saturating score, and a game-over state with restart. It sits between the board switch/LED pins and the score/status display logic.

Parameters:
N, 10, number of switches/LEDs (2..32)
LIVES, 3, misses allowed before game over (1..15)
TIMEOUT, 64, cycles allowed per round before a miss (2..65535)
SCORE_W, 8, score counter width
SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  level; begins/restarts a game in IDLE or GAMEOVER, ignored elsewhere
G  in  N  player switches
LED  out  N  one-hot target during SHOW; 0 in IDLE/RELEASE; all ones in GAMEOVER
wrong  out  1  one-cycle pulse on incorrect guess or timeout
hit  out  1  one-cycle pulse on correct guess
timeout  out  1  one-cycle pulse, coincident with wrong, when round timer expires
score  out  SCORE_W  correct guesses this game, saturating
lives  out  clog2(LIVES+1)  remaining lives
game_over  out  1  high while in GAMEOVER

Behaviour:
- Reset (async, any time, including mid-round): state=IDLE, LED=0, wrong=hit=timeout=0, score=0, lives=LIVES, game_over=0, lfsr=SEED, g_prev=0, timer=0, prev_idx=0.
- All outputs are registered.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Shifts every cycle in every state after reset.
- Candidate index: idx = lfsr % N. If idx == prev_idx, use (idx+1)%N instead, so two consecutive targets never repeat.
- Guess event: in SHOW when g_prev==0 and G!=0. g_prev is G registered every cycle.
- A held or bouncing nonzero G yields one event only; a new event needs G==0 first.
- States:
  - IDLE: LED=0. start=1 -> lives=LIVES, score=0, go to RELEASE.
  - RELEASE: LED=0. When sampled G==0, load the target for the next cycle: LED=1<<idx, prev_idx=idx, timer=0, go to SHOW. While G!=0, stay.
  - SHOW: timer increments each cycle.
    - On a guess event with G==LED exactly: hit=1 next cycle, score+1 (holds at 2^SCORE_W-1), go to RELEASE.
    - On a guess event with any other G (wrong bit, multiple bits): wrong=1, lives-1.
    - If there is no event and timer==TIMEOUT-1: wrong=1, timeout=1, lives-1.
    - After a miss, go to GAMEOVER if lives becomes 0, else RELEASE.
  - GAMEOVER: LED all ones, game_over=1. Score and lives are frozen. start=1 -> score=0, lives=LIVES, game_over=0, go to RELEASE.
- Latency:
  - Guess edge to hit/wrong: 1 cycle.
  - Release (G==0 sampled) to new target on LED: 1 cycle.
- Simultaneous guess event and timer expiry in the same cycle: the guess is judged and the timeout is not flagged.
- Pulses hit, wrong and timeout are never high more than one cycle. hit and wrong are never high together.
- score and lives update in the same cycle the pulse asserts.

Test Plan:
- Reset and start:
  - Assert reset for 1 ns mid-cycle -> LED=0, score=0, lives=3, game_over=0 immediately.
  - Pulse start with G=0 -> 2 cycles later LED is one-hot and state is SHOW.
- Correct guess:
  - Drive G=LED for 1 cycle after G=0 -> hit=1 for exactly 1 cycle, score=1, LED=0.
  - Then G=0 -> new one-hot LED, different from the previous one.
- Wrong guess:
  - LED=10'b0000000100, drive G=10'b0000000010 -> wrong=1, lives=2.
  - Hold G for 5 cycles -> no further pulses.
  - Drive G=10'b0000000110 (multi-bit) in a later round -> wrong=1.
- Timeout:
  - Leave G=0 in SHOW for 64 cycles -> wrong=timeout=1 on cycle 64, lives decremented, new target follows.
- Game over and restart:
  - Three misses -> lives=0, game_over=1, LED=10'b1111111111.
  - Guesses now have no effect.
  - start=1 -> score=0, lives=3, play resumes.
- Saturation and params:
  - SCORE_W=2 with 5 correct guesses -> score stays 3.
  - N=4, LIVES=1: one wrong -> GAMEOVER, LED=4'b1111.
  - Over 100 rounds, no consecutive repeat target.

Source files
------------

// File: rtl/guess_game_n.sv
// N-switch reaction game: shows a pseudo-random one-hot target on LED and scores
// edge-detected switch guesses, with per-round timeout, lives, saturating score and game over.
module guess_game_n #(
  parameter int          N       = 10,
  parameter int          LIVES   = 3,
  parameter int          TIMEOUT = 64,
  parameter int          SCORE_W = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [N-1:0]                   G,
  output logic [N-1:0]                   LED,
  output logic                           wrong,
  output logic                           hit,
  output logic                           timeout,
  output logic [SCORE_W-1:0]             score,
  output logic [$clog2(LIVES+1)-1:0]     lives,
  output logic                           game_over
);

  localparam int IW = $clog2(N);
  localparam int LW = $clog2(LIVES+1);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, RELEASE, SHOW, GAMEOVER} state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [N-1:0]         g_prev_q, g_prev_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        prev_idx_q, prev_idx_d;
  logic [N-1:0]         led_q, led_d;
  logic                 wrong_q, wrong_d;
  logic                 hit_q, hit_d;
  logic                 timeout_q, timeout_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LW-1:0]        lives_q, lives_d;
  logic                 game_over_q, game_over_d;

  logic [15:0]          lfsr_mod;
  logic [IW-1:0]        raw_idx;
  logic [IW-1:0]        idx;
  logic                 guess_evt;
  logic                 miss;
  logic                 unused_mod_bits;

  // Candidate target index, bumped by one when it would repeat the previous target
  always_comb begin
    lfsr_mod        = lfsr_q % 16'(N);
    raw_idx         = lfsr_mod[IW-1:0];
    unused_mod_bits = ^lfsr_mod[15:IW];
    idx             = raw_idx;
    if (raw_idx == prev_idx_q) begin
      idx = (raw_idx == IW'(N-1)) ? '0 : raw_idx + IW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    g_prev_d    = G;
    timer_d     = timer_q;
    prev_idx_d  = prev_idx_q;
    led_d       = led_q;
    wrong_d     = 1'b0;
    hit_d       = 1'b0;
    timeout_d   = 1'b0;
    score_d     = score_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    miss        = 1'b0;
    guess_evt   = (state_q == SHOW) && (g_prev_q == '0) && (G != '0);

    case (state_q)
      IDLE: begin
        led_d = '0;
        if (start) begin
          lives_d = LW'(LIVES);
          score_d = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        led_d = '0;
        if (G == '0) begin
          led_d      = {{(N-1){1'b0}}, 1'b1} << idx;
          prev_idx_d = idx;
          timer_d    = '0;
          state_d    = SHOW;
        end
      end
      SHOW: begin
        timer_d = timer_q + TW'(1);
        // A guess in the expiry cycle wins over the timeout
        if (guess_evt) begin
          if (G == led_q) begin
            hit_d   = 1'b1;
            score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
            led_d   = '0;
            state_d = RELEASE;
          end else begin
            miss = 1'b1;
          end
        end else if (timer_q == TW'(TIMEOUT-1)) begin
          miss      = 1'b1;
          timeout_d = 1'b1;
        end
        if (miss) begin
          wrong_d = 1'b1;
          lives_d = lives_q - LW'(1);
          if (lives_q == LW'(1)) begin
            led_d       = '1;
            game_over_d = 1'b1;
            state_d     = GAMEOVER;
          end else begin
            led_d   = '0;
            state_d = RELEASE;
          end
        end
      end
      GAMEOVER: begin
        led_d = '1;
        if (start) begin
          score_d     = '0;
          lives_d     = LW'(LIVES);
          game_over_d = 1'b0;
          led_d       = '0;
          state_d     = RELEASE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      g_prev_q    <= '0;
      timer_q     <= '0;
      prev_idx_q  <= '0;
      led_q       <= '0;
      wrong_q     <= 1'b0;
      hit_q       <= 1'b0;
      timeout_q   <= 1'b0;
      score_q     <= '0;
      lives_q     <= LW'(LIVES);
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      g_prev_q    <= g_prev_d;
      timer_q     <= timer_d;
      prev_idx_q  <= prev_idx_d;
      led_q       <= led_d;
      wrong_q     <= wrong_d;
      hit_q       <= hit_d;
      timeout_q   <= timeout_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
    end
  end

  assign LED       = led_q;
  assign wrong     = wrong_q;
  assign hit       = hit_q;
  assign timeout   = timeout_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_guess_game_n.sv
// Bench for guess_game_n: default 10-switch game plus a small N=4, LIVES=1, SCORE_W=2 instance.
module tb_guess_game_n;

  localparam int N  = 10;
  localparam int SW = 8;
  localparam int LW = 2;
  localparam int N1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic          reset, start;
  logic [N-1:0]  g, led;
  logic          wrong, hit, timeout, game_over;
  logic [SW-1:0] score;
  logic [LW-1:0] lives;

  // Small instance signals
  logic          reset1, start1;
  logic [N1-1:0] g1, led1;
  logic          wrong1, hit1, timeout1, game_over1;
  logic [1:0]    score1;
  logic [0:0]    lives1;

  guess_game_n #(.N(10), .LIVES(3), .TIMEOUT(64), .SCORE_W(8), .SEED(16'hACE1)) u0 (
    .clk(clk), .reset(reset), .start(start), .G(g), .LED(led), .wrong(wrong), .hit(hit),
    .timeout(timeout), .score(score), .lives(lives), .game_over(game_over));

  guess_game_n #(.N(4), .LIVES(1), .TIMEOUT(16), .SCORE_W(2), .SEED(16'hACE1)) u1 (
    .clk(clk), .reset(reset1), .start(start1), .G(g1), .LED(led1), .wrong(wrong1), .hit(hit1),
    .timeout(timeout1), .score(score1), .lives(lives1), .game_over(game_over1));

  typedef struct packed {
    logic          hit;
    logic          wrong;
    logic          tmo;
    logic [SW-1:0] score;
    logic [LW-1:0] lives;
    logic          go;
  } exp_t;

  exp_t         sb[$];
  exp_t         e, act;
  int           errors = 0;
  int           checks = 0;
  int           exp_score = 0;
  int           exp_lives = 3;
  logic [N-1:0] prev_led;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic h, input logic w, input logic t);
    exp_t x;
    x.hit   = h;
    x.wrong = w;
    x.tmo   = t;
    x.score = SW'(exp_score);
    x.lives = LW'(exp_lives);
    x.go    = (exp_lives == 0);
    sb.push_back(x);
  endtask

  function automatic logic [N-1:0] rot(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; g = '0;
    repeat (2) tick;
    reset = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0);
    tick;
    e = sb.pop_front();
    act = {hit, wrong, timeout, score, lives, game_over};
    checks++;
    if (act !== e || led !== '0) begin
      errors++; $display("[TB] FAIL reset_state: got %h led %b expected %h led 0", act, led, e);
    end
    start = 1'b1; tick; start = 1'b0; tick;
    checks++;
    if (!$onehot(led)) begin
      errors++; $display("[TB] FAIL start_target: got led %b expected one-hot", led);
    end
    // Mid-cycle asynchronous reset from SHOW
    #2; reset = 1'b1; #1;
    checks++;
    if ({led, score, lives, game_over} !== {{N{1'b0}}, 8'd0, 2'd3, 1'b0}) begin
      errors++; $display("[TB] FAIL async_reset: got led %b score %0d lives %0d go %b expected 0/0/3/0",
                         led, score, lives, game_over);
    end
    reset = 1'b0;
    tick;
    start = 1'b1; tick; start = 1'b0; tick;
    checks++;
    if (!$onehot(led)) begin
      errors++; $display("[TB] FAIL restart_target: got led %b expected one-hot", led);
    end
    prev_led = led;
  endtask

  task automatic test_correct_guess;
    g = led; exp_score++;
    push_exp(1'b1, 1'b0, 1'b0);
    tick;
    e = sb.pop_front(); act = {hit, wrong, timeout, score, lives, game_over};
    checks++;
    if (act !== e || led !== '0) begin
      errors++; $display("[TB] FAIL correct_hit: got %h led %b expected %h led 0", act, led, e);
    end
    push_exp(1'b0, 1'b0, 1'b0);
    tick;
    e = sb.pop_front(); act = {hit, wrong, timeout, score, lives, game_over};
    checks++;
    if (act !== e) begin
      errors++; $display("[TB] FAIL hit_one_cycle: got %h expected %h", act, e);
    end
    g = '0; tick;
    checks++;
    if (!$onehot(led) || led === prev_led) begin
      errors++; $display("[TB] FAIL next_target: got %b prev %b expected new one-hot", led, prev_led);
    end
    prev_led = led;
  endtask

  task automatic test_simultaneous;
    logic early;
    early = 1'b0;
    g = '0;
    repeat (63) begin
      tick;
      if (wrong || timeout || hit) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++; $display("[TB] FAIL early_pulse: got pulse before expiry expected none");
    end
    g = led; exp_score++;
    push_exp(1'b1, 1'b0, 1'b0);
    tick;
    e = sb.pop_front(); act = {hit, wrong, timeout, score, lives, game_over};
    checks++;
    if (act !== e) begin
      errors++; $display("[TB] FAIL guess_at_expiry: got %h expected %h", act, e);
    end
    g = '0; tick;
    prev_led = led;
  endtask

  task automatic test_wrong_guess;
    g = rot(led); exp_lives--;
    push_exp(1'b0, 1'b1, 1'b0);
    tick;
    e = sb.pop_front(); act = {hit, wrong, timeout, score, lives, game_over};
    checks++;
    if (act !== e || led !== '0) begin
      errors++; $display("[TB] FAIL wrong_single: got %h led %b expected %h led 0", act, led, e);
    end
    repeat (5) begin
      push_exp(1'b0, 1'b0, 1'b0);
      tick;
      e = sb.pop_front(); act = {hit, wrong, timeout, score, lives, game_over};
      checks++;
      if (act !== e || led !== '0) begin
        errors++; $display("[TB] FAIL held_no_pulse: got %h led %b expected %h led 0", act, led, e);
      end
    end
    g = '0; tick;
    checks++;
    if (!$onehot(led) || led === prev_led) begin
      errors++; $display("[TB] FAIL after_wrong_target: got %b prev %b expected new one-hot", led, prev_led);
    end
    prev_led = led;
  endtask

  task automatic test_timeout;
    logic early;
    early = 1'b0;
    repeat (63) begin
      tick;
      if (wrong || timeout || hit) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++; $display("[TB] FAIL timeout_early: got pulse before cycle 64 expected none");
    end
    exp_lives--;
    push_exp(1'b0, 1'b1, 1'b1);
    tick;
    e = sb.pop_front(); act = {hit, wrong, timeout, score, lives, game_over};
    checks++;
    if (act !== e) begin
      errors++; $display("[TB] FAIL timeout_pulse: got %h expected %h", act, e);
    end
    tick;
    checks++;
    if (!$onehot(led) || led === prev_led) begin
      errors++; $display("[TB] FAIL after_timeout_target: got %b prev %b expected new one-hot", led, prev_led);
    end
    prev_led = led;
  endtask

  task automatic test_game_over;
    g = led | rot(led); exp_lives--;
    push_exp(1'b0, 1'b1, 1'b0);
    tick;
    e = sb.pop_front(); act = {hit, wrong, timeout, score, lives, game_over};
    checks++;
    if (act !== e || led !== '1) begin
      errors++; $display("[TB] FAIL game_over_entry: got %h led %b expected %h led all ones", act, led, e);
    end
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 0) ? '0 : 10'b0000000100;
      push_exp(1'b0, 1'b0, 1'b0);
      tick;
      e = sb.pop_front(); act = {hit, wrong, timeout, score, lives, game_over};
      checks++;
      if (act !== e || led !== '1) begin
        errors++; $display("[TB] FAIL game_over_frozen: got %h led %b expected %h", act, led, e);
      end
    end
    g = '0; start = 1'b1; exp_score = 0; exp_lives = 3;
    push_exp(1'b0, 1'b0, 1'b0);
    tick;
    start = 1'b0;
    e = sb.pop_front(); act = {hit, wrong, timeout, score, lives, game_over};
    checks++;
    if (act !== e || led !== '0) begin
      errors++; $display("[TB] FAIL restart: got %h led %b expected %h led 0", act, led, e);
    end
    tick;
    checks++;
    if (!$onehot(led)) begin
      errors++; $display("[TB] FAIL restart_play: got led %b expected one-hot", led);
    end
    prev_led = led;
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 100; r++) begin
      g = led;
      if (exp_score < 255) exp_score++;
      push_exp(1'b1, 1'b0, 1'b0);
      tick;
      e = sb.pop_front(); act = {hit, wrong, timeout, score, lives, game_over};
      checks++;
      if (act !== e) begin
        errors++; $display("[TB] FAIL round_%0d_hit: got %h expected %h", r, act, e);
      end
      g = '0; tick;
      checks++;
      if (!$onehot(led) || led === prev_led) begin
        errors++; $display("[TB] FAIL round_%0d_target: got %b prev %b expected new one-hot", r, led, prev_led);
      end
      prev_led = led;
    end
  endtask

  task automatic test_params;
    logic [N1-1:0] p1;
    int            s1;
    s1 = 0;
    reset1 = 1'b0; g1 = '0; start1 = 1'b0;
    tick;
    start1 = 1'b1; tick; start1 = 1'b0; tick;
    checks++;
    if (!$onehot(led1)) begin
      errors++; $display("[TB] FAIL small_start: got led %b expected one-hot", led1);
    end
    p1 = led1;
    for (int k = 0; k < 5; k++) begin
      g1 = led1;
      if (s1 < 3) s1++;
      tick;
      checks++;
      if (hit1 !== 1'b1 || wrong1 !== 1'b0 || score1 !== 2'(s1)) begin
        errors++; $display("[TB] FAIL small_sat_%0d: got hit %b score %0d expected hit 1 score %0d",
                           k, hit1, score1, s1);
      end
      g1 = '0; tick;
      checks++;
      if (!$onehot(led1) || led1 === p1) begin
        errors++; $display("[TB] FAIL small_target_%0d: got %b prev %b expected new one-hot", k, led1, p1);
      end
      p1 = led1;
    end
    g1 = {led1[N1-2:0], led1[N1-1]};
    tick;
    checks++;
    if ({wrong1, game_over1, lives1, led1, score1} !== {1'b1, 1'b1, 1'b0, 4'b1111, 2'd3}) begin
      errors++; $display("[TB] FAIL small_game_over: got wrong %b go %b lives %0d led %b score %0d expected 1 1 0 1111 3",
                         wrong1, game_over1, lives1, led1, score1);
    end
    g1 = '0;
  endtask

  initial begin
    reset1 = 1'b1; start1 = 1'b0; g1 = '0;
    test_reset;
    test_correct_guess;
    test_simultaneous;
    test_wrong_guess;
    test_timeout;
    test_game_over;
    test_back_to_back;
    test_params;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
